// File: rtl/cypher_if.sv
// Bus between the cypher control FSM and cypher_datapath: symbol stream in,
// detection flag and status counters out.
interface cypher_if #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
);
  // Handshake: sl_op acts as valid and the datapath is always ready, so a
  // symbol is consumed at every edge where sl_op=1. There is no back-pressure.
  // sl_res is a synchronous clear and takes priority over sl_op.
  logic             sl_res;
  logic             sl_op;
  logic [SYM_W-1:0] data_in;
  logic             found;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] sym_count;
  logic             window_full;

  modport master (
    output sl_res, sl_op, data_in,
    input  found, match_count, sym_count, window_full
  );

  modport slave (
    input  sl_res, sl_op, data_in,
    output found, match_count, sym_count, window_full
  );
endinterface

// File: rtl/cypher_datapath.sv
// Sliding-window pattern detector with saturating match/symbol counters.
// Optional macro CYPHER_OVERLAP_EN: keep the window valid after a hit so overlapping matches count.
module cypher_datapath #(
  parameter int                         SYM_W   = 8,
  parameter int                         PAT_LEN = 4,
  parameter logic [PAT_LEN*SYM_W-1:0]   PATTERN = "CAFE",
  parameter int                         CNT_W   = 8
) (
  input  logic    clock,
  input  logic    reset,
  cypher_if.slave bus
);
  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0][SYM_W-1:0] window;
  logic [PAT_LEN-1:0][SYM_W-1:0] window_next;
  logic [FILL_W-1:0]             fill;
  logic [FILL_W-1:0]             fill_next;
  logic [FILL_W-1:0]             fill_after;
  logic                          hit;
  logic                          found;
  logic [CNT_W-1:0]              match_count;
  logic [CNT_W-1:0]              sym_count;
  logic                          window_full;

  // Match is judged on the window as it will look after this symbol shifts in.
  always_comb begin
    window_next = {window[PAT_LEN-2:0], bus.data_in};
    fill_next   = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
    hit         = (fill_next == FILL_MAX) && (window_next == PATTERN);
`ifdef CYPHER_OVERLAP_EN
    fill_after  = fill_next;
`else
    fill_after  = hit ? '0 : fill_next;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window      <= '0;
      fill        <= '0;
      found       <= 1'b0;
      match_count <= '0;
      sym_count   <= '0;
      window_full <= 1'b0;
    end else if (bus.sl_res) begin
      window      <= '0;
      fill        <= '0;
      found       <= 1'b0;
      match_count <= '0;
      sym_count   <= '0;
      window_full <= 1'b0;
    end else if (bus.sl_op) begin
      window      <= window_next;
      fill        <= fill_after;
      window_full <= (fill_after == FILL_MAX);
      found       <= hit;
      if (sym_count != '1) sym_count <= sym_count + CNT_W'(1);
      if (hit && (match_count != '1)) match_count <= match_count + CNT_W'(1);
    end else begin
      found <= 1'b0;
    end
  end

  assign bus.found       = found;
  assign bus.match_count = match_count;
  assign bus.sym_count   = sym_count;
  assign bus.window_full = window_full;
endmodule
